// File: rtl/mips_datapath.sv
// ---------------------------------------------------------------------------
// mips_datapath
//
// Multicycle MIPS-32 datapath. Every control signal comes from an external
// control FSM; this block only holds state and steers data.
//
// State: PC, IR, MDR, A, B, ALUOut and a 32 x 32-bit register file.
// Memory: one unified instruction/data memory, reached through ADR/RD/WD.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-low reset; clears all state
//   IorD        ADR select: 0 = PC, 1 = ALUOut
//   RegDst      reg write address: 0 = rt, 1 = rd
//   MemtoReg    reg write data: 0 = ALUOut, 1 = MDR
//   IRWrite     IR load enable
//   RegWrite    register-file write enable
//   ALUSrcA     ALU A: 0 = PC, 1 = A register
//   Branch      PC load when ALU Zero is set
//   PCWrite     unconditional PC load
//   ALUSrcB     ALU B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm << 2
//   PCSrc       next PC: 00/11 = ALUResult, 01 = ALUOut, 10 = jump target
//   ALUControl  ALU operation
//   RD          memory read data
//   ADR         memory address
//   WD          memory write data (B register)
//   overflow    signed overflow of the current add/sub
// ---------------------------------------------------------------------------
module mips_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic        IorD,
  input  logic        RegDst,
  input  logic        MemtoReg,
  input  logic        IRWrite,
  input  logic        RegWrite,
  input  logic        ALUSrcA,
  input  logic        Branch,
  input  logic        PCWrite,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  PCSrc,
  input  logic [2:0]  ALUControl,
  input  logic [31:0] RD,
  output logic [31:0] ADR,
  output logic [31:0] WD,
  output logic        overflow
);

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_ZERO = 3'b011;
  localparam logic [2:0] ALU_ANDN = 3'b100;
  localparam logic [2:0] ALU_ORN  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] mdr;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] alu_out;
  logic [31:0] regs [32];

  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa3;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] wd3;

  logic [31:0] sign_imm;
  logic [31:0] jump_target;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] pc_next;
  logic        pc_en;

  // Register-file addressing and read ports
  assign ra1 = ir[25:21];
  assign ra2 = ir[20:16];
  assign wa3 = RegDst ? ir[15:11] : ir[20:16];
  assign wd3 = MemtoReg ? mdr : alu_out;

  // Register 0 is forced to read zero regardless of array contents.
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

  // Immediate and jump target
  assign sign_imm    = {{16{ir[15]}}, ir[15:0]};
  assign jump_target = {pc[31:28], ir[25:0], 2'b00};

  // ALU operand muxes
  assign src_a = ALUSrcA ? a_reg : pc;

  always_comb begin
    src_b = b_reg;
    case (ALUSrcB)
      2'b00:   src_b = b_reg;
      2'b01:   src_b = 32'd4;
      2'b10:   src_b = sign_imm;
      2'b11:   src_b = {sign_imm[29:0], 2'b00};
      default: src_b = b_reg;
    endcase
  end

  assign sum  = src_a + src_b;
  assign diff = src_a - src_b;

  // ALU. SLT uses a true signed compare rather than the sign of diff so
  // that it stays correct when the subtraction overflows.
  always_comb begin
    alu_result = 32'd0;
    overflow   = 1'b0;
    case (ALUControl)
      ALU_ADD: begin
        alu_result = sum;
        overflow   = (src_a[31] == src_b[31]) && (sum[31] != src_a[31]);
      end
      ALU_SUB: begin
        alu_result = diff;
        overflow   = (src_a[31] != src_b[31]) && (diff[31] != src_a[31]);
      end
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_ANDN: alu_result = src_a & ~src_b;
      ALU_ORN:  alu_result = src_a | ~src_b;
      ALU_SLT:  alu_result = {31'd0, ($signed(src_a) < $signed(src_b))};
      ALU_ZERO: alu_result = 32'd0;
      default:  alu_result = 32'd0;
    endcase
  end

  assign zero = (alu_result == 32'd0);

  // Next-PC selection
  always_comb begin
    pc_next = alu_result;
    case (PCSrc)
      2'b00:   pc_next = alu_result;
      2'b01:   pc_next = alu_out;
      2'b10:   pc_next = jump_target;
      2'b11:   pc_next = alu_result;
      default: pc_next = alu_result;
    endcase
  end

  assign pc_en = PCWrite | (Branch & zero);

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc      <= 32'd0;
      ir      <= 32'd0;
      mdr     <= 32'd0;
      a_reg   <= 32'd0;
      b_reg   <= 32'd0;
      alu_out <= 32'd0;
    end else begin
      if (pc_en) begin
        pc <= pc_next;
      end
      if (IRWrite) begin
        ir <= RD;
      end
      mdr     <= RD;
      a_reg   <= rd1;
      b_reg   <= rd2;
      alu_out <= alu_result;
    end
  end

  // Register file write port. Address and data come from the current
  // (pre-edge) IR, so an IR load in the same cycle does not redirect it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (RegWrite && (wa3 != 5'd0)) begin
      regs[wa3] <= wd3;
    end
  end

  // Memory interface
  assign ADR = IorD ? alu_out : pc;
  assign WD  = b_reg;

endmodule

// File: tb/tb_mips_datapath.sv
module tb_mips_datapath;

  logic        clk;
  logic        rst;
  logic        IorD;
  logic        RegDst;
  logic        MemtoReg;
  logic        IRWrite;
  logic        RegWrite;
  logic        ALUSrcA;
  logic        Branch;
  logic        PCWrite;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSrc;
  logic [2:0]  ALUControl;
  logic [31:0] RD;
  logic [31:0] ADR;
  logic [31:0] WD;
  logic        overflow;

  int checks;
  int failures;

  mips_datapath dut (
    .clk        (clk),
    .rst        (rst),
    .IorD       (IorD),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .Branch     (Branch),
    .PCWrite    (PCWrite),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .ALUControl (ALUControl),
    .RD         (RD),
    .ADR        (ADR),
    .WD         (WD),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    Branch     = 1'b0;
    PCWrite    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    ALUControl = 3'b010;
    RD         = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] instr);
    idle();
    ALUSrcB = 2'b01;
    PCWrite = 1'b1;
    IRWrite = 1'b1;
    RD      = instr;
    tick();
    idle();
  endtask

  task automatic set_ir(input logic [31:0] instr);
    idle();
    IRWrite = 1'b1;
    RD      = instr;
    tick();
    idle();
  endtask

  // IR must have rt = target register; value goes through MDR.
  task automatic load_reg(input logic [31:0] instr, input logic [31:0] val);
    set_ir(instr);
    RD = val;
    tick();
    idle();
    MemtoReg = 1'b1;
    RegWrite = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (ADR !== 32'h0) begin
      failures++;
      $display("FAIL reset_adr got=%h exp=%h", ADR, 32'h0);
    end
    checks++;
    if (WD !== 32'h0) begin
      failures++;
      $display("FAIL reset_wd got=%h exp=%h", WD, 32'h0);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_overflow got=%b exp=0", overflow);
    end
    IorD = 1'b1;
    #1;
    checks++;
    if (ADR !== 32'h0) begin
      failures++;
      $display("FAIL reset_aluout got=%h exp=%h", ADR, 32'h0);
    end
    idle();
  endtask

  task automatic test_fetch();
    do_fetch(32'h20080005);
    checks++;
    if (ADR !== 32'h4) begin
      failures++;
      $display("FAIL fetch_pc got=%h exp=%h", ADR, 32'h4);
    end
    checks++;
    if (dut.ir !== 32'h20080005) begin
      failures++;
      $display("FAIL fetch_ir got=%h exp=%h", dut.ir, 32'h20080005);
    end
  endtask

  task automatic test_addi();
    // decode
    idle();
    tick();
    // execute: A(0) + 5
    ALUSrcA = 1'b1;
    ALUSrcB = 2'b10;
    tick();
    idle();
    IorD = 1'b1;
    #1;
    checks++;
    if (ADR !== 32'h5) begin
      failures++;
      $display("FAIL addi_aluout got=%h exp=%h", ADR, 32'h5);
    end
    // writeback $8
    idle();
    RegWrite = 1'b1;
    tick();
    // sw $8, 0($0)
    do_fetch(32'hAC080000);
    checks++;
    if (ADR !== 32'h8) begin
      failures++;
      $display("FAIL sw_fetch_pc got=%h exp=%h", ADR, 32'h8);
    end
    tick();
    checks++;
    if (WD !== 32'h5) begin
      failures++;
      $display("FAIL sw_wd got=%h exp=%h", WD, 32'h5);
    end
    ALUSrcA = 1'b1;
    ALUSrcB = 2'b10;
    tick();
    idle();
    IorD = 1'b1;
    #1;
    checks++;
    if (ADR !== 32'h0) begin
      failures++;
      $display("FAIL sw_adr got=%h exp=%h", ADR, 32'h0);
    end
    idle();
  endtask

  task automatic test_load();
    // lw with rt = rd = 10
    do_fetch(32'h8C0A5000);
    IorD = 1'b1;
    RD   = 32'hDEADBEEF;
    tick();
    // writeback to rd while IR is reloaded with a beq whose rd field is 0;
    // the write must still target register 10
    idle();
    RegDst   = 1'b1;
    MemtoReg = 1'b1;
    RegWrite = 1'b1;
    IRWrite  = 1'b1;
    RD       = 32'h114A0003;
    tick();
    idle();
    checks++;
    if (WD !== 32'h0) begin
      failures++;
      $display("FAIL load_read_old got=%h exp=%h", WD, 32'h0);
    end
  endtask

  task automatic test_branch();
    // beq $10,$10,3 at PC=12: decode computes PC + (3<<2) = 24
    ALUSrcB = 2'b11;
    tick();
    checks++;
    if (WD !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL load_wd got=%h exp=%h", WD, 32'hDEADBEEF);
    end
    idle();
    ALUSrcA    = 1'b1;
    ALUControl = 3'b110;
    Branch     = 1'b1;
    PCSrc      = 2'b01;
    tick();
    idle();
    checks++;
    if (ADR !== 32'd24) begin
      failures++;
      $display("FAIL beq_taken got=%h exp=%h", ADR, 32'd24);
    end
    // beq $10,$8,3 at PC=24 -> PC 28, not taken
    do_fetch(32'h11480003);
    ALUSrcB = 2'b11;
    tick();
    idle();
    ALUSrcA    = 1'b1;
    ALUControl = 3'b110;
    Branch     = 1'b1;
    PCSrc      = 2'b01;
    tick();
    idle();
    checks++;
    if (ADR !== 32'd28) begin
      failures++;
      $display("FAIL beq_not_taken got=%h exp=%h", ADR, 32'd28);
    end
    // PCWrite with Branch and Zero=0: loads ALUOut = 0xDEADBEEF - 5
    ALUSrcA    = 1'b1;
    ALUControl = 3'b110;
    Branch     = 1'b1;
    PCWrite    = 1'b1;
    PCSrc      = 2'b01;
    tick();
    idle();
    checks++;
    if (ADR !== 32'hDEADBEEA) begin
      failures++;
      $display("FAIL pcwrite_branch got=%h exp=%h", ADR, 32'hDEADBEEA);
    end
  endtask

  task automatic test_jump();
    do_fetch(32'h08000100);
    PCWrite = 1'b1;
    PCSrc   = 2'b10;
    tick();
    idle();
    checks++;
    if (ADR !== 32'hD0000400) begin
      failures++;
      $display("FAIL jump_pc got=%h exp=%h", ADR, 32'hD0000400);
    end
  endtask

  task automatic test_reg0();
    // IR = 0x08000100: rt = rd = 0
    RD = 32'h12345678;
    tick();
    idle();
    MemtoReg = 1'b1;
    RegWrite = 1'b1;
    tick();
    idle();
    tick();
    checks++;
    if (WD !== 32'h0) begin
      failures++;
      $display("FAIL reg0_write got=%h exp=%h", WD, 32'h0);
    end
  endtask

  task automatic test_overflow();
    load_reg(32'h8C010000, 32'h7FFFFFFF);
    load_reg(32'h8C020000, 32'h00000001);
    load_reg(32'h8C030000, 32'h80000000);
    // add $1,$2
    set_ir(32'h00220020);
    tick();
    ALUSrcA = 1'b1;
    #1;
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL add_overflow got=%b exp=1", overflow);
    end
    tick();
    idle();
    IorD = 1'b1;
    #1;
    checks++;
    if (ADR !== 32'h80000000) begin
      failures++;
      $display("FAIL add_result got=%h exp=%h", ADR, 32'h80000000);
    end
    // sub $3,$2
    set_ir(32'h00620022);
    tick();
    ALUSrcA    = 1'b1;
    ALUControl = 3'b110;
    #1;
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL sub_overflow got=%b exp=1", overflow);
    end
    tick();
    idle();
    IorD = 1'b1;
    #1;
    checks++;
    if (ADR !== 32'h7FFFFFFF) begin
      failures++;
      $display("FAIL sub_result got=%h exp=%h", ADR, 32'h7FFFFFFF);
    end
    idle();
    ALUSrcA    = 1'b1;
    ALUControl = 3'b111;
    #1;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL slt_overflow got=%b exp=0", overflow);
    end
    tick();
    idle();
    IorD = 1'b1;
    #1;
    checks++;
    if (ADR !== 32'h1) begin
      failures++;
      $display("FAIL slt_result got=%h exp=%h", ADR, 32'h1);
    end
    idle();
  endtask

  task automatic test_alu_ops();
    // A = 0x80000000, B = 1 from IR 0x00620022
    logic [2:0]  op_t  [6];
    logic [31:0] exp_t [6];
    op_t  = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b011, 3'b010};
    exp_t = '{32'h00000000, 32'h80000001, 32'h80000000,
              32'hFFFFFFFE, 32'h00000000, 32'h80000001};
    for (int i = 0; i < 6; i++) begin
      idle();
      ALUSrcA    = 1'b1;
      ALUControl = op_t[i];
      #1;
      checks++;
      if (overflow !== 1'b0) begin
        failures++;
        $display("FAIL alu_op%0d_overflow got=%b exp=0", op_t[i], overflow);
      end
      tick();
      idle();
      IorD = 1'b1;
      #1;
      checks++;
      if (ADR !== exp_t[i]) begin
        failures++;
        $display("FAIL alu_op%0d got=%h exp=%h", op_t[i], ADR, exp_t[i]);
      end
    end
    idle();
  endtask

  task automatic test_reset_priority();
    idle();
    ALUSrcB  = 2'b01;
    PCWrite  = 1'b1;
    IRWrite  = 1'b1;
    RegWrite = 1'b1;
    RD       = 32'hFFFFFFFF;
    rst      = 1'b0;
    tick();
    rst = 1'b1;
    idle();
    #1;
    checks++;
    if (ADR !== 32'h0) begin
      failures++;
      $display("FAIL rst_priority_pc got=%h exp=%h", ADR, 32'h0);
    end
    checks++;
    if (dut.ir !== 32'h0) begin
      failures++;
      $display("FAIL rst_priority_ir got=%h exp=%h", dut.ir, 32'h0);
    end
    // IR was reloaded with $1/$2 fields earlier; cleared regfile must read 0
    set_ir(32'h00220020);
    tick();
    checks++;
    if (WD !== 32'h0) begin
      failures++;
      $display("FAIL rst_regfile got=%h exp=%h", WD, 32'h0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    idle();
    test_reset();
    test_fetch();
    test_addi();
    test_load();
    test_branch();
    test_jump();
    test_reg0();
    test_overflow();
    test_alu_ops();
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
